// File: rtl/muldiv_pkg.sv
// Shared opcode constants, op/state enums and decode for the M-extension co-processors.
// Definitions only: no state, no timing.
package muldiv_pkg;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP32      = 7'b0111011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    MULW   = 3'd4
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    COOL
  } mul_state_e;

  typedef struct packed {
    logic    vld;
    mul_op_e op;
  } mul_dec_t;

  // funct3 1xx belongs to the divider and must stay invisible here.
  function automatic mul_dec_t mul_decode(input logic [31:0] insn, input logic rv64);
    mul_dec_t d;
    d.vld = 1'b0;
    d.op  = MUL;
    if (insn[31:25] == FUNCT7_MULDIV) begin
      if (insn[6:0] == OPC_OP && insn[14] == 1'b0) begin
        d.vld = 1'b1;
        d.op  = mul_op_e'({1'b0, insn[13:12]});
      end else if (rv64 && insn[6:0] == OPC_OP32 && insn[14:12] == 3'b000) begin
        d.vld = 1'b1;
        d.op  = MULW;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/mul_pipe.sv
// Signed W x W multiplier followed by LATENCY-1 register stages; result valid LATENCY-1 cycles after en_i.
// No backpressure: the first stage holds while en_i is low, later stages shift every cycle.
module mul_pipe #(
  parameter int W       = 33,
  parameter int LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic [2*W-3:0]    p_o
);
  localparam int PW = 2*W-2;

  logic signed [PW-1:0] prod;

  // The top two bits of the full product are never consumed, so compute at PW.
  assign prod = PW'(a_i) * PW'(b_i);

  generate
    if (LATENCY == 1) begin : g_comb
      assign p_o = prod;
    end else begin : g_reg
      logic [PW-1:0] stage_q [LATENCY-1];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < LATENCY-1; i++) stage_q[i] <= '0;
        end else begin
          if (en_i) stage_q[0] <= prod;
          for (int i = 1; i < LATENCY-1; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign p_o = stage_q[LATENCY-2];
    end
  endgenerate

endmodule

// File: rtl/pcpi_fused_mul.sv
// PCPI multiply co-processor (MUL/MULH/MULHSU/MULHU, MULW on RV64) with a one-entry product cache.
// Ready LATENCY cycles after accept on a miss, 1 on a hit; pcpi_wait stalls the core, dropping pcpi_valid aborts.
module pcpi_fused_mul
  import muldiv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int LATENCY     = 2,
  parameter bit ENABLE_FUSE = 1'b1,
  parameter bit ENABLE_WAIT = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd,
  output logic            pcpi_wait,
  output logic            pcpi_ready
);
  localparam int PW = 2*XLEN;

  function automatic logic [XLEN-1:0] pick(input mul_op_e op, input logic [PW-1:0] p);
    case (op)
      MUL:     return p[XLEN-1:0];
      MULW:    return XLEN'($signed(p[31:0]));
      default: return p[PW-1:XLEN];
    endcase
  endfunction

  mul_state_e      state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  mul_op_e         op_q, op_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            cache_vld_q, cache_vld_d;
  mul_op_e         cache_op_q, cache_op_d;
  logic [XLEN-1:0] cache_rs1_q, cache_rs1_d, cache_rs2_q, cache_rs2_d;
  logic [PW-1:0]   cache_prod_q, cache_prod_d;

  mul_dec_t          dec;
  logic              req;
  logic              hit;
  logic              pipe_en;
  logic signed [XLEN:0] a_ext, b_ext;
  logic [PW-1:0]     prod;

  assign dec = mul_decode(pcpi_insn, XLEN == 64);
  assign req = (state_q == IDLE) && pcpi_valid && dec.vld;

  // Low half is signedness-independent, so MUL may reuse any entry except MULW's.
  assign hit = ENABLE_FUSE && cache_vld_q &&
               (pcpi_rs1 == cache_rs1_q) && (pcpi_rs2 == cache_rs2_q) &&
               ((dec.op == MUL && cache_op_q != MULW) || (dec.op == cache_op_q));

  assign pipe_en = req && !hit;

  always_comb begin
    a_ext = {1'b0, pcpi_rs1};
    b_ext = {1'b0, pcpi_rs2};
    case (dec.op)
      MULH: begin
        a_ext = {pcpi_rs1[XLEN-1], pcpi_rs1};
        b_ext = {pcpi_rs2[XLEN-1], pcpi_rs2};
      end
      MULHSU: a_ext = {pcpi_rs1[XLEN-1], pcpi_rs1};
      MULW: begin
        a_ext = (XLEN+1)'($signed(pcpi_rs1[31:0]));
        b_ext = (XLEN+1)'($signed(pcpi_rs2[31:0]));
      end
      default: ;
    endcase
  end

  mul_pipe #(
    .W       (XLEN+1),
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk_i  (clk),
    .rst_ni (resetn),
    .en_i   (pipe_en),
    .a_i    (a_ext),
    .b_i    (b_ext),
    .p_o    (prod)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    res_d        = res_q;
    cache_vld_d  = cache_vld_q;
    cache_op_d   = cache_op_q;
    cache_rs1_d  = cache_rs1_q;
    cache_rs2_d  = cache_rs2_q;
    cache_prod_d = cache_prod_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          op_d  = dec.op;
          rs1_d = pcpi_rs1;
          rs2_d = pcpi_rs2;
          if (hit) begin
            res_d   = pick(dec.op, cache_prod_q);
            state_d = DONE;
          end else if (LATENCY == 1) begin
            res_d        = pick(dec.op, prod);
            cache_vld_d  = 1'b1;
            cache_op_d   = dec.op;
            cache_rs1_d  = pcpi_rs1;
            cache_rs2_d  = pcpi_rs2;
            cache_prod_d = prod;
            state_d      = DONE;
          end else begin
            cnt_d   = 3'(LATENCY-1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 3'd1;
        if (!pcpi_valid) begin
          state_d = IDLE;
        end else if (cnt_d == 3'd0) begin
          res_d        = pick(op_q, prod);
          cache_vld_d  = 1'b1;
          cache_op_d   = op_q;
          cache_rs1_d  = rs1_q;
          cache_rs2_d  = rs2_q;
          cache_prod_d = prod;
          state_d      = DONE;
        end
      end
      DONE:    state_d = COOL;
      COOL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= MUL;
      rs1_q        <= '0;
      rs2_q        <= '0;
      res_q        <= '0;
      cache_vld_q  <= 1'b0;
      cache_op_q   <= MUL;
      cache_rs1_q  <= '0;
      cache_rs2_q  <= '0;
      cache_prod_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      res_q        <= res_d;
      cache_vld_q  <= cache_vld_d;
      cache_op_q   <= cache_op_d;
      cache_rs1_q  <= cache_rs1_d;
      cache_rs2_q  <= cache_rs2_d;
      cache_prod_q <= cache_prod_d;
    end
  end

  assign pcpi_ready = (state_q == DONE);
  assign pcpi_wr    = pcpi_ready;
  assign pcpi_rd    = pcpi_ready ? res_q : '0;
  // resetn gates the accept term so every output is 0 throughout reset.
  assign pcpi_wait  = ENABLE_WAIT && resetn && ((state_q == BUSY) || req);

endmodule

// File: tb/tb_pcpi_fused_mul.sv
// Bench for pcpi_fused_mul: an RV32 LATENCY=3 instance and an RV64 LATENCY=1 instance.
// Requests push expected results to per-instance queues; monitors pop and compare on pcpi_ready.
module tb_pcpi_fused_mul;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        v32, w32, r32, wr32;
  logic [31:0] insn32, a32, b32, rd32;
  logic        v64, w64, r64, wr64;
  logic [31:0] insn64;
  logic [63:0] a64, b64, rd64;

  pcpi_fused_mul #(.XLEN(32), .LATENCY(3)) u32 (
    .clk(clk), .resetn(resetn), .pcpi_valid(v32), .pcpi_insn(insn32),
    .pcpi_rs1(a32), .pcpi_rs2(b32), .pcpi_wr(wr32), .pcpi_rd(rd32),
    .pcpi_wait(w32), .pcpi_ready(r32)
  );

  pcpi_fused_mul #(.XLEN(64), .LATENCY(1)) u64 (
    .clk(clk), .resetn(resetn), .pcpi_valid(v64), .pcpi_insn(insn64),
    .pcpi_rs1(a64), .pcpi_rs2(b64), .pcpi_wr(wr64), .pcpi_rd(rd64),
    .pcpi_wait(w64), .pcpi_ready(r64)
  );

  typedef struct {
    logic [63:0] rd;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          d64;
    logic [31:0] insn;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  exp_t q32[$];
  exp_t q64[$];
  int   cyc = 0;
  int   nerr = 0;
  int   nchk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] opc);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  function automatic logic [63:0] ref32(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f3)
      3'd0:    p = ua * ub;
      3'd1:    p = sa * sb;
      3'd2:    p = sa * ub;
      default: p = ua * ub;
    endcase
    if (f3 == 3'd0) return {32'd0, p[31:0]};
    return {32'd0, p[63:32]};
  endfunction

  always @(negedge clk) begin
    exp_t it;
    if (r32) begin
      if (q32.size() == 0) chk("unexpected_ready32", 64'd1, 64'd0);
      else begin
        it = q32.pop_front();
        chk("rd32", {32'd0, rd32}, it.rd);
        chk("lat32", 64'(cyc), 64'(it.cyc));
        chk("wr32", {63'd0, wr32}, 64'd1);
      end
    end
    if (r64) begin
      if (q64.size() == 0) chk("unexpected_ready64", 64'd1, 64'd0);
      else begin
        it = q64.pop_front();
        chk("rd64", rd64, it.rd);
        chk("lat64", 64'(cyc), 64'(it.cyc));
        chk("wr64", {63'd0, wr64}, 64'd1);
      end
    end
  end

  task automatic drive(input bit d64, input logic v, input logic [31:0] insn,
                       input logic [63:0] a, input logic [63:0] b);
    if (d64) begin
      v64 = v; insn64 = insn; a64 = a; b64 = b;
    end else begin
      v32 = v; insn32 = insn; a32 = a[31:0]; b32 = b[31:0];
    end
  endtask

  task automatic req(input bit d64, input logic [31:0] insn, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] exp, input int lat);
    int          t0;
    bit          got;
    logic        w, r;
    logic [63:0] rdv;
    exp_t        e;
    @(posedge clk); #1;
    drive(d64, 1'b1, insn, a, b);
    t0    = cyc;
    e.rd  = exp;
    e.cyc = t0 + lat;
    if (d64) q64.push_back(e); else q32.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      w   = d64 ? w64 : w32;
      r   = d64 ? r64 : r32;
      rdv = d64 ? rd64 : {32'd0, rd32};
      if (r) begin
        got = 1'b1;
        chk("wait_in_done", {63'd0, w}, 64'd0);
      end else begin
        chk("wait", {63'd0, w}, {63'd0, k < lat});
        chk("rd_zero", rdv, 64'd0);
      end
    end
    if (!got) begin
      chk("ready_timeout", 64'd0, 64'd1);
      if (d64) void'(q64.pop_back()); else void'(q32.pop_back());
    end
    @(posedge clk); #1;
    drive(d64, 1'b0, insn, a, b);
    @(posedge clk);
  endtask

  task automatic ign(input bit d64, input logic [31:0] insn, input string nm);
    int bad = 0;
    @(posedge clk); #1;
    drive(d64, 1'b1, insn, 64'd3, 64'd4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (d64 ? (w64 || r64) : (w32 || r32)) bad++;
    end
    chk(nm, 64'(bad), 64'd0);
    @(posedge clk); #1;
    drive(d64, 1'b0, insn, 64'd0, 64'd0);
  endtask

  task automatic abort_at(input int busy_cyc, input logic [31:0] b, input string nm);
    int rdy = 0;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, mk(3'd0, 7'b0110011), 64'd5, {32'd0, b});
    @(negedge clk);
    chk({nm, "_wait0"}, {63'd0, w32}, 64'd1);
    repeat (busy_cyc) @(posedge clk);
    #1 v32 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (r32) rdy++;
    end
    chk({nm, "_no_ready"}, 64'(rdy), 64'd0);
    chk({nm, "_idle_wait"}, {63'd0, w32}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  localparam logic [6:0] OP   = 7'b0110011;
  localparam logic [6:0] OP32 = 7'b0111011;
  localparam logic [63:0] F32 = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] F64 = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    vec_t        tbl[$];
    logic [2:0]  f3;
    logic [31:0] ra, rb;

    resetn = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 32'd0, 64'd0, 64'd0);
    #3;
    chk("reset_out32", {60'd0, w32, r32, wr32, |rd32}, 64'd0);
    chk("reset_out64", {60'd0, w64, r64, wr64, |rd64}, 64'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    tbl.push_back('{0, mk(3'd0, OP), 64'd7, 64'd6, 64'd42, 3});
    tbl.push_back('{0, mk(3'd1, OP), F32, F32, 64'h0, 3});
    tbl.push_back('{0, mk(3'd3, OP), F32, F32, 64'hFFFF_FFFE, 3});
    tbl.push_back('{0, mk(3'd2, OP), F32, F32, 64'hFFFF_FFFF, 3});
    tbl.push_back('{0, mk(3'd3, OP), F32, F32, 64'hFFFF_FFFE, 3});
    tbl.push_back('{0, mk(3'd0, OP), F32, F32, 64'h1, 1});
    tbl.push_back('{0, mk(3'd1, OP), F32, F32, 64'h0, 3});
    tbl.push_back('{0, mk(3'd1, OP), F32, F32, 64'h0, 1});
    tbl.push_back('{0, mk(3'd0, OP), F32, F32, 64'h1, 1});
    tbl.push_back('{0, mk(3'd2, OP), 64'h8000_0000, F32, 64'h8000_0000, 3});
    tbl.push_back('{0, mk(3'd1, OP), 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 3});
    tbl.push_back('{0, mk(3'd0, OP), 64'h8000_0000, 64'h8000_0000, 64'h0, 1});
    tbl.push_back('{1, mk(3'd0, OP32), 64'h4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000, 1});
    tbl.push_back('{1, mk(3'd0, OP), 64'h4000_0000, 64'd2, 64'h0000_0000_8000_0000, 1});
    tbl.push_back('{1, mk(3'd0, OP32), 64'hDEAD_BEEF_0000_0003, 64'h1234_5678_FFFF_FFFF,
                   64'hFFFF_FFFF_FFFF_FFFD, 1});
    tbl.push_back('{1, mk(3'd1, OP), F64, 64'd2, F64, 1});
    tbl.push_back('{1, mk(3'd3, OP), F64, 64'd2, 64'd1, 1});
    tbl.push_back('{1, mk(3'd0, OP), F64, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1});
    tbl.push_back('{1, mk(3'd2, OP), F64, 64'd2, F64, 1});

    for (int i = 0; i < tbl.size(); i++)
      req(tbl[i].d64, tbl[i].insn, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);

    // High-half miss followed by a fused MUL on the same operands.
    for (int i = 0; i < 6; i++) begin
      f3 = 3'($urandom_range(1, 3));
      ra = $urandom;
      rb = $urandom;
      req(0, mk(f3, OP), {32'd0, ra}, {32'd0, rb}, ref32(f3, ra, rb), 3);
      req(0, mk(3'd0, OP), {32'd0, ra}, {32'd0, rb}, ref32(3'd0, ra, rb), 1);
    end

    ign(0, mk(3'd4, OP), "div_ignored32");
    ign(0, mk(3'd0, OP32), "mulw_ignored32");
    ign(1, mk(3'd4, OP), "div_ignored64");
    ign(1, {7'b0000000, 5'd2, 5'd1, 3'd0, 5'd3, OP}, "add_ignored64");

    abort_at(1, 32'd9, "abort_busy1");
    req(0, mk(3'd0, OP), 64'd5, 64'd9, 64'd45, 3);
    abort_at(2, 32'd10, "abort_busy_last");
    req(0, mk(3'd0, OP), 64'd5, 64'd10, 64'd50, 3);

    req(0, mk(3'd0, OP), 64'd11, 64'd13, 64'd143, 3);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, mk(3'd1, OP), 64'd11, 64'd13);
    @(posedge clk); #2;
    chk("rst_pre_wait", {63'd0, w32}, 64'd1);
    resetn = 1'b0;
    #1;
    chk("rst_async_out32", {60'd0, w32, r32, wr32, |rd32}, 64'd0);
    @(posedge clk); #1 v32 = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    req(0, mk(3'd0, OP), 64'd11, 64'd13, 64'd143, 3);

    repeat (4) @(posedge clk);
    chk("queues_drained", 64'(q32.size() + q64.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/pcpi_fused_mul.md
Name: pcpi_fused_mul

Overview:
Parametrised PCPI co-processor for the RISC-V M-extension multiplies: MUL, MULH, MULHSU, MULHU, plus MULW when XLEN=64.
- Configurable operand width and pipeline latency.
- Busy signalling on pcpi_wait.
- Clean abort when the core withdraws a request.
- A one-entry product cache, so a MUL/MULH pair on the same operands costs one multiply (fused MULH+MUL sequence).
- Attaches to the core's PCPI port alongside the divider.

Parameters:
- XLEN, 32: operand/result width; legal values 32 or 64.
- LATENCY, 2: cycles from request accept to pcpi_ready for a computed result; legal range 1..6.
- ENABLE_FUSE, 1: when 1, the product cache is enabled; when 0, every request computes.
- ENABLE_WAIT, 1: when 1, pcpi_wait is driven while busy; when 0, pcpi_wait is tied 0.

Ports:
- clk  in  1  clock; all logic on posedge.
- resetn  in  1  reset, asynchronous, active-low.
- pcpi_valid  in  1  core presents an instruction.
- pcpi_insn  in  32  instruction word.
- pcpi_rs1  in  XLEN  operand 1.
- pcpi_rs2  in  XLEN  operand 2.
- pcpi_wr  out  1  result write enable; equal to pcpi_ready.
- pcpi_rd  out  XLEN  result; valid only while pcpi_ready=1, otherwise 0.
- pcpi_wait  out  1  instruction recognised and in progress.
- pcpi_ready  out  1  one-cycle result strobe.

Behaviour:
- Reset: asynchronous and active-low. While resetn=0:
  - state=IDLE, cache invalid, counter cleared.
  - pcpi_wr, pcpi_ready, pcpi_wait and pcpi_rd are all 0.
  - Reset mid-operation discards the operation; no ready is issued.
- Decode:
  - opcode 0110011 with funct7 0000001 and funct3 000/001/010/011 selects MUL/MULH/MULHSU/MULHU.
  - If XLEN=64, opcode 0111011 with funct7 0000001 and funct3 000 selects MULW.
  - Anything else, including funct3 1xx (divides), is ignored: no wait, no ready.
- Operand extension: each operand is extended to XLEN+1 bits, sign-extended if that operand is signed for the op, else zero-extended.
  - rs1 is signed for MULH and MULHSU.
  - rs2 is signed for MULH only.
  - MUL uses unsigned extension.
  - MULW multiplies the sign-extended low 32 bits of each operand.
- Arithmetic: signed multiply of the extended operands gives a 2*XLEN product.
  - MUL: product[XLEN-1:0].
  - MULH, MULHSU, MULHU: product[2*XLEN-1:XLEN].
  - MULW: product[31:0], sign-extended to 64 bits.
- FSM states: IDLE, BUSY, DONE, COOL.
  - IDLE: on a decoded request with a cache hit, go to DONE; on a decoded request with a miss, capture operands and mode, load counter=LATENCY-1, go to BUSY (if LATENCY=1, go directly to DONE).
  - BUSY: counter decrements each cycle. When it reaches 0, go to DONE and write the product and operands into the cache.
  - DONE: pcpi_ready=pcpi_wr=1 for exactly one cycle, driving pcpi_rd; then go to COOL.
  - COOL: pcpi_valid is ignored for one cycle (the core drops valid the cycle after ready); then go to IDLE.
- Latency: for a request first seen at cycle 0, pcpi_ready is asserted at cycle LATENCY on a miss and at cycle 1 on a hit.
- pcpi_wait: 1 in BUSY and in the IDLE cycle that accepts a request; 0 otherwise. Tied 0 if ENABLE_WAIT=0.
- Cache hit condition: cache valid, ENABLE_FUSE=1, rs1 and rs2 bit-equal to the cached operands, and either:
  - the op is MUL (low half is independent of signedness), or
  - the op is the same mode as the cached entry (MULH, MULHSU, MULHU, or MULW).
  - MULW is cached as its own mode.
- Abort: if pcpi_valid falls while in BUSY, go to IDLE next cycle; no ready is issued and the cache is not updated.
- Cache persistence: only reset invalidates the cache. Operand comparison makes a stale hit impossible.
- Back-to-back: a new request is accepted in the first IDLE cycle after COOL. The earliest re-accept is 2 cycles after DONE.

Decomposition:
- Shared package muldiv_pkg holds:
  - mul_op_e enum {MUL, MULH, MULHSU, MULHU, MULW}.
  - OPC_OP and OPC_OP32 opcode constants.
  - FUNCT7_MULDIV constant.
  - Decode function returning mul_op_e plus a valid bit.
- Sub-module mul_pipe #(W=XLEN+1, LATENCY):
  - signed multiply with LATENCY-1 retiming register stages and an input enable;
  - instantiated once.

Test Plan:
- XLEN=32, LATENCY=3, MUL rs1=7, rs2=6: pcpi_wait=1 at cycles 0..2, pcpi_ready and pcpi_rd=42 at cycle 3 only.
- MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000; MULHU same operands → 0xFFFFFFFE; MULHSU same operands → 0xFFFFFFFF. Each is a miss with ready at cycle 3.
- Fusion: MULHU 0xFFFFFFFF,0xFFFFFFFF (miss) then MUL with the same operands → 0x00000001 with ready 1 cycle after accept. A following MULH with the same operands misses.
- XLEN=64, MULW rs1=0x0000_0000_4000_0000, rs2=2 → 0xFFFF_FFFF_8000_0000. DIV encoding (funct3=100) → no wait and no ready for 10 cycles.
- Abort and reset:
  - Drop pcpi_valid in BUSY cycle 1 → IDLE, no ready; reissuing the same request misses.
  - resetn low mid-BUSY → all outputs 0 immediately (asynchronously); after release, the next same-operand MUL misses.
